// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_pipe
// Purpose  : Three-stage pipelined FP adder/subtractor, valid/ready handshake,
//            truncate or round-to-nearest-even, flush-to-zero, exception flags.
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    input  logic         rnd_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid
);

    localparam int c_al_w  = MAN_W + 3;              // hidden, mantissa, G, R
    localparam int c_ext_w = MAN_W + 4;              // plus sticky
    localparam int c_lz_w  = $clog2(c_ext_w + 1);
    localparam int c_xw    = ((EXP_W > c_lz_w) ? EXP_W : c_lz_w) + 2;
    localparam logic [EXP_W-1:0] c_exp_max = {EXP_W{1'b1}};
    localparam logic [c_xw-1:0]  c_emax_x  = {{(c_xw-EXP_W){1'b0}}, {EXP_W{1'b1}}};
    localparam logic [W-1:0]     c_qnan    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // ---------------- flow control ----------------
    logic r_init, r_v1, r_v2;
    logic w_stall, w_en, w_accept;

    assign w_stall  = out_valid & ~out_ready;
    assign w_en     = ~w_stall;
    assign in_ready = r_init & ~w_stall;
    assign w_accept = in_valid & in_ready;

    // ---------------- stage 1: unpack, classify, swap ----------------
    logic             w1_as, w1_bs;
    logic [EXP_W-1:0] w1_ae, w1_be;
    logic [MAN_W-1:0] w1_am, w1_bm;
    logic             w1_a_zero, w1_a_inf, w1_a_nan, w1_b_zero, w1_b_inf, w1_b_nan;
    logic             w1_swap, w1_spec, w1_inv;
    logic [W-1:0]     w1_spec_res;

    assign w1_as = a[W-1];
    assign w1_ae = a[W-2:MAN_W];
    assign w1_am = a[MAN_W-1:0];
    assign w1_bs = b[W-1] ^ op;
    assign w1_be = b[W-2:MAN_W];
    assign w1_bm = b[MAN_W-1:0];

    assign w1_a_zero = (w1_ae == '0);
    assign w1_a_inf  = (w1_ae == c_exp_max) && (w1_am == '0);
    assign w1_a_nan  = (w1_ae == c_exp_max) && (w1_am != '0);
    assign w1_b_zero = (w1_be == '0);
    assign w1_b_inf  = (w1_be == c_exp_max) && (w1_bm == '0);
    assign w1_b_nan  = (w1_be == c_exp_max) && (w1_bm != '0);
    assign w1_swap   = (b[W-2:0] > a[W-2:0]);

    always_comb begin
        w1_spec     = 1'b1;
        w1_inv      = 1'b0;
        w1_spec_res = a;
        if (w1_a_nan)
            w1_spec_res = a;
        else if (w1_b_nan)
            w1_spec_res = {w1_bs, b[W-2:0]};
        else if (w1_a_inf && w1_b_inf && (w1_as != w1_bs)) begin
            w1_spec_res = c_qnan;
            w1_inv      = 1'b1;
        end else if (w1_a_inf)
            w1_spec_res = a;
        else if (w1_b_inf)
            w1_spec_res = {w1_bs, b[W-2:0]};
        else if (w1_a_zero && w1_b_zero)
            w1_spec_res = {w1_as & w1_bs, {(W-1){1'b0}}};
        else if (w1_b_zero)
            w1_spec_res = a;
        else if (w1_a_zero)
            w1_spec_res = {w1_bs, b[W-2:0]};
        else
            w1_spec = 1'b0;
    end

    logic             r1_spec, r1_inv, r1_sign, r1_sub, r1_rnd;
    logic [W-1:0]     r1_spec_res;
    logic [EXP_W-1:0] r1_exp, r1_diff;
    logic [MAN_W:0]   r1_mbig, r1_msml;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_init      <= 1'b0;
            r_v1        <= 1'b0;
            r1_spec     <= 1'b0;
            r1_inv      <= 1'b0;
            r1_sign     <= 1'b0;
            r1_sub      <= 1'b0;
            r1_rnd      <= 1'b0;
            r1_spec_res <= '0;
            r1_exp      <= '0;
            r1_diff     <= '0;
            r1_mbig     <= '0;
            r1_msml     <= '0;
        end else begin
            r_init <= 1'b1;
            if (w_en) begin
                r_v1        <= w_accept;
                r1_spec     <= w1_spec;
                r1_inv      <= w1_inv;
                r1_sign     <= w1_swap ? w1_bs : w1_as;
                r1_sub      <= w1_as ^ w1_bs;
                r1_rnd      <= rnd_mode;
                r1_spec_res <= w1_spec_res;
                r1_exp      <= w1_swap ? w1_be : w1_ae;
                r1_diff     <= w1_swap ? (w1_be - w1_ae) : (w1_ae - w1_be);
                r1_mbig     <= w1_swap ? {1'b1, w1_bm} : {1'b1, w1_am};
                r1_msml     <= w1_swap ? {1'b1, w1_am} : {1'b1, w1_bm};
            end
        end
    end

    // ---------------- stage 2: align with G/R/S, add or subtract ----------------
    logic [c_al_w-1:0]  w2_pre, w2_sh;
    logic               w2_st;
    logic [31:0]        w2_d;
    logic [c_ext_w-1:0] w2_big, w2_small;
    logic [c_ext_w:0]   w2_mag;

    assign w2_pre = {r1_msml, 2'b00};
    assign w2_d   = 32'(r1_diff);

    always_comb begin
        w2_sh = '0;
        w2_st = 1'b0;
        if (w2_d >= 32'(c_al_w)) begin
            w2_st = |w2_pre;
        end else begin
            w2_sh = w2_pre >> w2_d;
            for (int i = 0; i < c_al_w; i++)
                if (32'(i) < w2_d) w2_st = w2_st | w2_pre[i];
        end
    end

    assign w2_big   = {r1_mbig, 3'b000};
    assign w2_small = {w2_sh, w2_st};
    assign w2_mag   = r1_sub ? ({1'b0, w2_big} - {1'b0, w2_small})
                             : ({1'b0, w2_big} + {1'b0, w2_small});

    logic               r2_spec, r2_inv, r2_sign, r2_rnd;
    logic [W-1:0]       r2_spec_res;
    logic [EXP_W-1:0]   r2_exp;
    logic [c_ext_w:0]   r2_mag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v2        <= 1'b0;
            r2_spec     <= 1'b0;
            r2_inv      <= 1'b0;
            r2_sign     <= 1'b0;
            r2_rnd      <= 1'b0;
            r2_spec_res <= '0;
            r2_exp      <= '0;
            r2_mag      <= '0;
        end else if (w_en) begin
            r_v2        <= r_v1;
            r2_spec     <= r1_spec;
            r2_inv      <= r1_inv;
            r2_sign     <= r1_sign;
            r2_rnd      <= r1_rnd;
            r2_spec_res <= r1_spec_res;
            r2_exp      <= r1_exp;
            r2_mag      <= w2_mag;
        end
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    logic [c_lz_w-1:0]  w3_lz;
    logic [c_ext_w-1:0] w3_norm;
    logic [c_xw-1:0]    w3_enorm, w3_efin;
    logic [MAN_W+1:0]   w3_rm;
    logic [MAN_W-1:0]   w3_man;
    logic               w3_inc, w3_unf, w3_ovf;
    logic [W-1:0]       w3_res;
    logic               w3_f_ovf, w3_f_unf, w3_f_inv;

    always_comb begin
        w3_lz = '0;
        for (int i = 0; i < c_ext_w; i++)
            if (r2_mag[i]) w3_lz = c_lz_w'(c_ext_w - 1 - i);
    end

    // A carry shifts right once, folding the lost bit into sticky.
    always_comb begin
        if (r2_mag[c_ext_w]) begin
            w3_norm  = {r2_mag[c_ext_w:2], r2_mag[1] | r2_mag[0]};
            w3_enorm = c_xw'(r2_exp) + {{(c_xw-1){1'b0}}, 1'b1};
        end else begin
            w3_norm  = r2_mag[c_ext_w-1:0] << w3_lz;
            w3_enorm = c_xw'(r2_exp) - c_xw'(w3_lz);
        end
    end

    assign w3_inc  = r2_rnd & w3_norm[2] & (w3_norm[1] | w3_norm[0] | w3_norm[3]);
    assign w3_rm   = {1'b0, w3_norm[c_ext_w-1:3]} + {{(MAN_W+1){1'b0}}, w3_inc};
    assign w3_man  = w3_rm[MAN_W+1] ? '0 : w3_rm[MAN_W-1:0];
    assign w3_efin = w3_enorm + {{(c_xw-1){1'b0}}, w3_rm[MAN_W+1]};
    assign w3_unf  = w3_efin[c_xw-1] | (w3_efin == '0);
    assign w3_ovf  = ~w3_unf & (w3_efin >= c_emax_x);

    always_comb begin
        w3_res   = {r2_sign, w3_efin[EXP_W-1:0], w3_man};
        w3_f_ovf = 1'b0;
        w3_f_unf = 1'b0;
        w3_f_inv = 1'b0;
        if (r2_spec) begin
            w3_res   = r2_spec_res;
            w3_f_inv = r2_inv;
        end else if (r2_mag == '0) begin
            w3_res = '0;
        end else if (w3_unf) begin
            w3_res   = {r2_sign, {(W-1){1'b0}}};
            w3_f_unf = 1'b1;
        end else if (w3_ovf) begin
            w3_res   = {r2_sign, c_exp_max, {MAN_W{1'b0}}};
            w3_f_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else if (w_en) begin
            out_valid <= r_v2;
            sum       <= w3_res;
            overflow  <= r_v2 & w3_f_ovf;
            underflow <= r_v2 & w3_f_unf;
            invalid   <= r_v2 & w3_f_inv;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_pipe
// Purpose  : Directed self-checking bench with an expected-result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, op, rnd_mode;
    logic        out_valid, out_ready, overflow, underflow, invalid;
    logic [31:0] a, b, sum;

    logic        h_in_valid, h_in_ready, h_op, h_rnd;
    logic        h_out_valid, h_out_ready, h_ovf, h_unf, h_inv;
    logic [15:0] h_a, h_b, h_sum;

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .rnd_mode(rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .op(h_op), .rnd_mode(h_rnd),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .sum(h_sum), .overflow(h_ovf), .underflow(h_unf), .invalid(h_inv)
    );

    typedef struct {
        logic [31:0] sum;
        logic [2:0]  flags;    // {overflow, underflow, invalid}
        int          cyc;
        bit          lat;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard consumer: a result is taken when it is presented with out_ready high.
    exp_t m_e;
    always @(negedge clk) begin
        #1;
        if (reset && out_valid && out_ready) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_result: observed %h expected none", sum);
            end
            if (q.size() > 0) begin
                m_e = q.pop_front();
                chk({m_e.tag, "_sum"}, sum, m_e.sum);
                chk({m_e.tag, "_flags"}, {29'd0, overflow, underflow, invalid}, {29'd0, m_e.flags});
                if (m_e.lat) chk({m_e.tag, "_latency"}, cyc - m_e.cyc, 3);
            end
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic top,
                        input logic trnd, input logic [31:0] esum, input logic [2:0] eflg,
                        input bit lat, input string tag);
        exp_t e;
        int   n = 0;
        a = ta; b = tb_; op = top; rnd_mode = trnd; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL %s_accept: observed no in_ready expected accept within 50 cycles", tag);
        end
        e.sum = esum; e.flags = eflg; e.cyc = cyc; e.lat = lat; e.tag = tag;
        if (n < 50) q.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; rnd_mode = 1'b0;
        out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_op = 1'b0; h_rnd = 1'b1; h_out_ready = 1'b1;
        #2 reset = 1'b0;
        repeat (2) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {overflow, underflow, invalid}, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        step();
        chk("rst_in_ready", in_ready, 1);

        // Basic add in both rounding modes, with latency check.
        send(32'h42019999, 32'h4124CCCC, 1'b0, 1'b0, 32'h422ACCCC, 3'b000, 1, "t1_trunc");
        send(32'h42019999, 32'h4124CCCC, 1'b0, 1'b1, 32'h422ACCCC, 3'b000, 1, "t1_rne");
        // Exact tie: RNE rounds to even (up here), truncate drops it.
        send(32'h3F800001, 32'h33800000, 1'b0, 1'b1, 32'h3F800002, 3'b000, 1, "t2_rne");
        send(32'h3F800001, 32'h33800000, 1'b0, 1'b0, 32'h3F800001, 3'b000, 1, "t2_trunc");
        // Rounding carry-out renormalises into the next binade.
        send(32'h3FFFFFFF, 32'h33800000, 1'b0, 1'b1, 32'h40000000, 3'b000, 1, "rnd_carry");
        send(32'h3FFFFFFF, 32'h33800000, 1'b0, 1'b0, 32'h3FFFFFFF, 3'b000, 1, "rnd_carry_tr");
        // Overflow in both modes, inf - inf.
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F800000, 3'b100, 1, "t3_ovf_rne");
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 3'b100, 1, "t3_ovf_tr");
        send(32'h7F800000, 32'hFF800000, 1'b0, 1'b1, 32'h7FC00000, 3'b001, 1, "t3_inv");
        // Exact cancellation, NaN passthrough, zero + x.
        send(32'h42440000, 32'h42440000, 1'b1, 1'b1, 32'h00000000, 3'b000, 1, "t4_cancel");
        send(32'h7F800001, 32'hC243B852, 1'b1, 1'b1, 32'h7F800001, 3'b000, 1, "t4_nan");
        send(32'h00000000, 32'hC243B852, 1'b0, 1'b1, 32'hC243B852, 3'b000, 1, "t4_zero");
        send(32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 3'b000, 1, "negzero");
        // Tiny differences near the minimum normal flush to signed zero.
        send(32'h00800001, 32'h00800000, 1'b1, 1'b1, 32'h00000000, 3'b010, 1, "unf_pos");
        send(32'h80800001, 32'h00800000, 1'b0, 1'b1, 32'h80000000, 3'b010, 1, "unf_neg");
        drain("directed");

        // Back-to-back stream with a 4-cycle output stall.
        fork
            begin
                send(32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 32'h40000000, 3'b000, 0, "t5_0");
                send(32'h40000000, 32'h3F800000, 1'b0, 1'b1, 32'h40400000, 3'b000, 0, "t5_1");
                send(32'h40400000, 32'h3F800000, 1'b0, 1'b1, 32'h40800000, 3'b000, 0, "t5_2");
                send(32'h40800000, 32'h40800000, 1'b0, 1'b1, 32'h41000000, 3'b000, 0, "t5_3");
                send(32'h41000000, 32'h3F800000, 1'b1, 1'b1, 32'h40E00000, 3'b000, 0, "t5_4");
            end
            begin
                @(negedge clk);
                @(negedge clk);
                out_ready = 1'b0;
                @(negedge clk);
                #2;
                chk("t5_in_ready_stalled", in_ready, 0);
                chk("t5_out_valid_stalled", out_valid, 1);
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain("t5");

        // Reset while two results are in flight: they must vanish.
        send(32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 32'h40000000, 3'b000, 0, "rst_a");
        send(32'h40000000, 32'h3F800000, 1'b0, 1'b1, 32'h40400000, 3'b000, 0, "rst_b");
        @(negedge clk);
        chk("t6_valid_before_rst", out_valid, 1);
        reset = 1'b0;
        q.delete();
        #2;
        chk("t6_valid_in_rst", out_valid, 0);
        chk("t6_sum_in_rst", sum, 0);
        chk("t6_flags_in_rst", {overflow, underflow, invalid}, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        repeat (6) step();
        chk("t6_no_stale_valid", out_valid, 0);
        chk("t6_in_ready_after", in_ready, 1);

        // Half-precision instance: 1.0 + 1.0.
        h_a = 16'h3C00; h_b = 16'h3C00; h_in_valid = 1'b1;
        chk("half_in_ready", h_in_ready, 1);
        step();
        h_in_valid = 1'b0;
        begin
            int n = 0;
            while (!h_out_valid && n < 20) begin
                step();
                n++;
            end
        end
        chk("half_valid", h_out_valid, 1);
        chk("half_sum", h_sum, 16'h4000);
        chk("half_flags", {h_ovf, h_unf, h_inv}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, pipelined floating-point adder/subtractor; next generation of the registered single-precision adder.
- Adds configurable exponent and mantissa widths, an add/subtract op and selectable rounding (truncate or round-to-nearest-even).
- Adds valid/ready flow control with backpressure and per-result exception flags.
- Sits between the operand register file and the result bus of the FP datapath.

Parameters:
EXP_W, 8, exponent field width (>=4)
MAN_W, 23, stored mantissa width, excluding the hidden bit (>=4)
W, EXP_W+MAN_W+1, total word width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
a  in  W  operand A {sign, exp, man}
b  in  W  operand B
op  in  1  0 = a+b, 1 = a-b (b sign inverted at capture)
rnd_mode  in  1  0 = truncate toward zero, 1 = round-to-nearest-even
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  W  result
overflow  out  1  finite operands produced a result too large to represent
underflow  out  1  nonzero result flushed to zero
invalid  out  1  inf - inf; canonical NaN returned

Behaviour:
- Reset (reset=0, async): all pipeline valid bits 0; out_valid, sum, overflow, underflow, invalid = 0. in_ready = 1 one cycle after release. Reset mid-operation discards all in-flight results.
- Pipeline: 3 registered stages; latency 3 cycles from accepted input to out_valid.
  - S1: unpack, classify (zero/inf/NaN), swap so |A|>=|B|, compute exponent difference.
  - S2: align the smaller operand with guard/round/sticky (sticky ORs all shifted-out bits; shift >= MAN_W+3 leaves only sticky), then add or subtract.
  - S3: normalise via leading-zero count, round, pack, set flags.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - Accept on in_valid & in_ready. When stalled, every stage holds; nothing is dropped or duplicated; order is preserved.
  - Bubbles advance normally. out_valid deasserts on out_valid & out_ready with no new result behind it.
- Subnormals: inputs with exp=0 are treated as signed zero (flush-to-zero).
- Special cases, in priority order:
  - a is NaN: sum = a unchanged.
  - else b is NaN: sum = b, with sign post-op.
  - inf + (-inf): sum = {0, all-ones exp, 1, zeros} and invalid = 1.
  - inf ± finite: sum = that inf.
  - x + 0 or 0 + x: sum = x bit-exact.
- Zero sign: exact cancellation gives +0; (-0)+(-0) gives -0.
- Rounding:
  - Truncate drops G/R/S.
  - RNE increments when G & (R | S | lsb).
  - Mantissa carry-out from rounding renormalises (exp+1).
- Overflow: biased exponent reaches all-ones after normalise or round gives sum = ±inf and overflow = 1, in both rounding modes.
- Underflow: biased exponent <= 0 with nonzero magnitude gives signed zero and underflow = 1.
- Flags are sideband of sum, valid only while out_valid = 1, held during a stall.

Test Plan:
1. a=0x42019999 (32.4), b=0x4124CCCC (10.3), op=0, either rnd_mode -> sum=0x422ACCCC, all flags 0, out_valid exactly 3 cycles after acceptance.
2. a=0x3F800001, b=0x33800000 (tie case) -> rnd_mode=1: sum=0x3F800002; rnd_mode=0: sum=0x3F800001.
3. a=0x7F7FFFFF, b=0x7F7FFFFF -> sum=0x7F800000, overflow=1. Then a=0x7F800000, b=0xFF800000 -> sum=0x7FC00000, invalid=1.
4. op=1, a=b=0x42440000 (49.0) -> sum=0x00000000. Then a=0x7F800001 (NaN), b=0xC243B852 -> sum=0x7F800001. Then a=0, b=0xC243B852 -> sum=0xC243B852.
5. Back-to-back: 5 operand pairs on consecutive cycles with out_ready held low for cycles 3-6 -> in_ready drops while stalled; all 5 results emerge in order, none lost or repeated.
6. Assert reset for 1 cycle while 2 results are in flight -> outputs clear immediately; no stale out_valid after release. Also instantiate EXP_W=5, MAN_W=10: a=0x3C00 (1.0), b=0x3C00 -> sum=0x4000.
